// File: rtl/w0rm_periph_arbiter.sv
// Round-robin arbiter that shares the W0RM demo peripheral bus among several masters.
// Optional watchdog abort is enabled with `define W0RM_ARB_TIMEOUT_EN.
module w0rm_periph_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [NUM_MASTERS-1:0]           m_valid_i,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr_i,
  input  logic [NUM_MASTERS-1:0]           m_write_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_data_i,
  output logic [NUM_MASTERS-1:0]           m_ack_o,
  output logic [NUM_MASTERS-1:0]           m_err_o,
  output logic [DATA_WIDTH-1:0]            m_data_o,
  output logic [NUM_MASTERS-1:0]           grant_o,
  output logic                             busy_o,
  output logic                             s_valid_o,
  output logic [ADDR_WIDTH-1:0]            s_addr_o,
  output logic                             s_write_o,
  output logic [DATA_WIDTH-1:0]            s_data_o,
  input  logic                             s_ready_i,
  input  logic                             s_resp_valid_i,
  input  logic [DATA_WIDTH-1:0]            s_resp_data_i
);

  localparam int PTR_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t                   state, state_nx;
  logic [PTR_W-1:0]         last, last_nx;
  logic [PTR_W-1:0]         owner, owner_nx;
  logic [NUM_MASTERS-1:0]   grant_nx, ack_nx, eligible;
  logic [DATA_WIDTH-1:0]    m_data_nx, s_data_nx;
  logic [ADDR_WIDTH-1:0]    s_addr_nx;
  logic                     busy_nx, s_valid_nx, s_write_nx;
  logic                     found, done;
  logic [PTR_W-1:0]         winner;

`ifdef W0RM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]         cnt, cnt_nx;
  logic [NUM_MASTERS-1:0]   err_nx;
`endif

  // A master still showing its ack this cycle is masked so a held valid is not re-granted.
  always_comb begin
    int idx;
    idx      = 0;
    found    = 1'b0;
    winner   = '0;
    eligible = m_valid_i & ~m_ack_o;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      idx = int'(last) + k;
      if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
      if (!found && eligible[idx]) begin
        found  = 1'b1;
        winner = idx[PTR_W-1:0];
      end
    end
  end

  assign done = ((state == REQ) && s_ready_i && s_resp_valid_i) ||
                ((state == RESP) && s_resp_valid_i);

  always_comb begin
    state_nx   = state;
    last_nx    = last;
    owner_nx   = owner;
    grant_nx   = grant_o;
    busy_nx    = busy_o;
    s_valid_nx = s_valid_o;
    s_addr_nx  = s_addr_o;
    s_write_nx = s_write_o;
    s_data_nx  = s_data_o;
    ack_nx     = '0;
    m_data_nx  = '0;
`ifdef W0RM_ARB_TIMEOUT_EN
    cnt_nx     = cnt;
    err_nx     = '0;
`endif
    case (state)
      IDLE: begin
        if (found) begin
          owner_nx         = winner;
          grant_nx         = '0;
          grant_nx[winner] = 1'b1;
          s_addr_nx        = m_addr_i[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
          s_write_nx       = m_write_i[winner];
          s_data_nx        = m_data_i[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
          s_valid_nx       = 1'b1;
          busy_nx          = 1'b1;
          state_nx         = REQ;
`ifdef W0RM_ARB_TIMEOUT_EN
          cnt_nx           = '0;
`endif
        end
      end
      REQ, RESP: begin
        if (done) begin
          ack_nx[owner] = 1'b1;
          m_data_nx     = s_write_o ? '0 : s_resp_data_i;
          last_nx       = owner;
          grant_nx      = '0;
          busy_nx       = 1'b0;
          s_valid_nx    = 1'b0;
          state_nx      = IDLE;
        end
`ifdef W0RM_ARB_TIMEOUT_EN
        else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          ack_nx[owner] = 1'b1;
          err_nx[owner] = 1'b1;
          m_data_nx     = '1;
          last_nx       = owner;
          grant_nx      = '0;
          busy_nx       = 1'b0;
          s_valid_nx    = 1'b0;
          state_nx      = IDLE;
        end
`endif
        else begin
          if ((state == REQ) && s_ready_i) begin
            s_valid_nx = 1'b0;
            state_nx   = RESP;
          end
`ifdef W0RM_ARB_TIMEOUT_EN
          cnt_nx = cnt + 1'b1;
`endif
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      last      <= PTR_W'(NUM_MASTERS - 1);
      owner     <= '0;
      grant_o   <= '0;
      busy_o    <= 1'b0;
      s_valid_o <= 1'b0;
      s_addr_o  <= '0;
      s_write_o <= 1'b0;
      s_data_o  <= '0;
      m_ack_o   <= '0;
      m_data_o  <= '0;
    end else begin
      state     <= state_nx;
      last      <= last_nx;
      owner     <= owner_nx;
      grant_o   <= grant_nx;
      busy_o    <= busy_nx;
      s_valid_o <= s_valid_nx;
      s_addr_o  <= s_addr_nx;
      s_write_o <= s_write_nx;
      s_data_o  <= s_data_nx;
      m_ack_o   <= ack_nx;
      m_data_o  <= m_data_nx;
    end
  end

`ifdef W0RM_ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt     <= '0;
      m_err_o <= '0;
    end else begin
      cnt     <= cnt_nx;
      m_err_o <= err_nx;
    end
  end
`else
  assign m_err_o = '0;
`endif

endmodule

// File: doc/w0rm_periph_arbiter.md
Name: w0rm_periph_arbiter

Overview:
- Round-robin arbiter and transaction sequencer that shares the W0RM demo peripheral bus (the GPIO block driving LEDs, switches and mode_select) among NUM_MASTERS requesters, e.g. the CPU data port and a demo pattern sequencer.
- Latches one master's request, drives a single slave transaction with a valid/ready issue phase and a response phase, then returns a one-cycle acknowledge to the owning master.
- Sits between the masters and the GPIO/peripheral decoder inside W0RM_Demo.

Parameters:
- NUM_MASTERS, 2, number of requesters (2..8).
- ADDR_WIDTH, 32, peripheral address width.
- DATA_WIDTH, 32, data width.
- TIMEOUT_CYCLES, 64, abort threshold. Used only with the optional feature.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  synchronous active-low reset.
- m_valid_i  input  NUM_MASTERS  per-master request; held until that master's ack.
- m_addr_i  input  NUM_MASTERS*ADDR_WIDTH  flattened addresses; master i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- m_write_i  input  NUM_MASTERS  1 = write, 0 = read.
- m_data_i  input  NUM_MASTERS*DATA_WIDTH  flattened write data.
- m_ack_o  output  NUM_MASTERS  one-cycle completion pulse, one-hot.
- m_err_o  output  NUM_MASTERS  one-cycle error pulse, coincident with ack.
- m_data_o  output  DATA_WIDTH  read data; valid while any m_ack_o bit is high.
- grant_o  output  NUM_MASTERS  one-hot current owner; 0 when idle.
- busy_o  output  1  high in REQ or RESP.
- s_valid_o  output  1  slave request.
- s_addr_o  output  ADDR_WIDTH  latched address.
- s_write_o  output  1  latched direction.
- s_data_o  output  DATA_WIDTH  latched write data.
- s_ready_i  input  1  slave accepts the request.
- s_resp_valid_i  input  1  slave completes; required for both reads and writes.
- s_resp_data_i  input  DATA_WIDTH  read data.

Behaviour:
- Clock and reset: single clock clk; reset_n is synchronous and active-low.
- Reset values: all outputs 0; state = IDLE; last-grant pointer = NUM_MASTERS-1, so master 0 has first priority.
- All outputs are registered.

States:
- IDLE:
  - Eligible masters are those with m_valid_i high and m_ack_o low in the current cycle. The ack mask prevents re-granting a master that has not yet dropped valid.
  - Priority search starts at (last+1) mod NUM_MASTERS and wraps.
  - On a winner: latch its addr/write/data into s_*_o, set grant_o, set s_valid_o=1 and busy_o=1, then go to REQ.
  - No eligible master: stay in IDLE.
- REQ:
  - Hold s_valid_o and all s_*_o stable until s_ready_i=1.
  - On s_ready_i: clear s_valid_o and go to RESP.
  - If s_ready_i and s_resp_valid_i are both high in the same cycle, complete directly as in RESP.
- RESP:
  - Wait for s_resp_valid_i.
  - On it: m_ack_o[g]=1 for one cycle, m_data_o=s_resp_data_i (0 for writes), last=g, grant_o=0, busy_o=0, go to IDLE.
  - m_data_o returns to 0 the cycle after ack.

Timing and boundary rules:
- Latency: request seen in cycle 0 gives s_valid_o in cycle 1. With s_ready in cycle 1 and response in cycle 2, ack appears in cycle 3.
- Back-to-back: the next grant is decided in the ack cycle, so the next s_valid_o comes 1 cycle after the ack.
- Changes to m_* inputs during REQ/RESP are ignored, because the request is latched.
- A master dropping m_valid_i mid-transaction still receives its ack.
- s_ready_i or s_resp_valid_i arriving in IDLE, or s_resp_valid_i arriving in REQ before s_ready_i, is ignored.
- Reset asserted mid-transaction: immediate return to reset values on the next edge; no ack is issued.
- Fairness: with all masters continuously requesting, grants rotate 0,1,…,N-1,0.

Optional Feature:
- Macro: W0RM_ARB_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on entry to REQ and increments each cycle in REQ/RESP.
  - When it reaches TIMEOUT_CYCLES without completion: s_valid_o=0, m_ack_o[g]=1 and m_err_o[g]=1 for one cycle, m_data_o all ones, last=g, go to IDLE.
  - A late s_resp_valid_i after the abort is ignored.
- Not defined: no counter; the arbiter waits indefinitely; m_err_o is tied to 0.

Test Plan:
- Single read: master 0 reads addr 0x10; s_ready in cycle 1, resp 0xA5 in cycle 2 -> s_valid_o high in cycle 1 only, m_ack_o=01 and m_data_o=0xA5 in cycle 3, grant_o=00 after.
- Contention and round-robin: both masters hold valid for 4 transactions, slave 0-wait -> grant sequence 01,10,01,10; each ack pulses exactly one cycle.
- Stall: master 1 writes 0x55 to 0x20; s_ready held low 5 cycles -> s_valid_o, s_addr_o=0x20, s_data_o=0x55 stable throughout; ack after resp; m_data_o=0.
- Input change: master 0 changes m_addr_i from 0x10 to 0x30 during REQ -> s_addr_o stays 0x10.
- Reset mid-RESP: reset_n low one cycle -> all outputs 0 next edge; a later resp is ignored; master 0 is granted first after release.
- Timeout (W0RM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8): slave never responds -> ack and err pulse exactly 8 cycles after REQ entry, m_data_o all ones; without the macro, busy_o stays high.
